// File: rtl/seq_cmd_scheduler_pkg.sv
// Shared types for the sequencer command scheduler: descriptor layout and FSM states.
package seq_pkg;

    localparam int unsigned DATA_NUM_W = 9;
    localparam int unsigned REP_W      = 32;
    localparam int unsigned WAIT_W     = 32;
    localparam int unsigned DESC_W     = DATA_NUM_W + REP_W + WAIT_W;

    typedef struct packed {
        logic [DATA_NUM_W-1:0] data_num;
        logic [REP_W-1:0]      repetition;
        logic [WAIT_W-1:0]     wait_num;
    } desc_t;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSkip,
        StKick,
        StArm,
        StRun,
        StFinish,
        StStopping
    } state_t;

endpackage

// File: rtl/seq_cmd_scheduler_if.sv
// Descriptor ingress handshake plus the sequencer control/status bundle.
interface seq_cmd_scheduler_if;

    logic [seq_pkg::DATA_NUM_W-1:0] cmd_data_num;
    logic [seq_pkg::REP_W-1:0]      cmd_repetition;
    logic [seq_pkg::WAIT_W-1:0]     cmd_wait_num;
    logic                           cmd_valid;
    logic                           cmd_ready;

    logic [seq_pkg::DATA_NUM_W-1:0] seq_data_num;
    logic [seq_pkg::REP_W-1:0]      seq_repetition;
    logic [seq_pkg::WAIT_W-1:0]     seq_wait_num;
    logic                           seq_kick;
    logic                           seq_stop;
    logic                           seq_busy;

    // The scheduler is the slave of the descriptor stream.
    modport slave (
        input  cmd_data_num, cmd_repetition, cmd_wait_num, cmd_valid, seq_busy,
        output cmd_ready, seq_data_num, seq_repetition, seq_wait_num, seq_kick, seq_stop
    );

    modport master (
        output cmd_data_num, cmd_repetition, cmd_wait_num, cmd_valid, seq_busy,
        input  cmd_ready, seq_data_num, seq_repetition, seq_wait_num, seq_kick, seq_stop
    );

endinterface

// File: rtl/seq_desc_fifo.sv
// Synchronous descriptor FIFO with first-word fall-through read and a flush that wins over push/pop.
module seq_desc_fifo
    import seq_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic [DESC_W-1:0]         wdata,
    input  logic                      pop,
    input  logic                      flush,
    output logic [DESC_W-1:0]         rdata,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DESC_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wptr_q, rptr_q;
    logic [CW-1:0]     count_q;
    logic              do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    assign rdata   = mem_q[rptr_q];
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata;
    end

endmodule

// File: rtl/seq_cmd_scheduler.sv
// Queues playback descriptors and issues them to the waveform sequencer one after another,
// kicking each only once the previous segment's busy has risen and fallen (or timed out).
module seq_cmd_scheduler
    import seq_pkg::*;
#(
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned BUSY_TIMEOUT = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    seq_cmd_scheduler_if.slave     bus,
    input  logic                   abort,
    output logic [$clog2(DEPTH):0] queue_count,
    output logic                   active,
    output logic                   seg_done,
    output logic [31:0]            done_count
);

    localparam int unsigned TW = $clog2(BUSY_TIMEOUT + 1);

    state_t            state_q, state_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    desc_t             head, seg_q;
    logic [DESC_W-1:0] head_bits;
    logic              push, pop, fifo_full, fifo_empty;
    logic              stop_d, stop_q;
    logic [31:0]       done_count_q;

    assign bus.cmd_ready = ~fifo_full & ~abort & (state_q != StStopping);
    assign push          = bus.cmd_valid & bus.cmd_ready;
    assign head          = desc_t'(head_bits);

    seq_desc_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata ({bus.cmd_data_num, bus.cmd_repetition, bus.cmd_wait_num}),
        .pop   (pop),
        .flush (abort),
        .rdata (head_bits),
        .count (queue_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        pop     = 1'b0;
        stop_d  = 1'b0;
        unique case (state_q)
            // A busy sequencer started elsewhere must drain before we kick it.
            StIdle: begin
                if (!abort && !fifo_empty && !bus.seq_busy) begin
                    pop     = 1'b1;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (seg_q.data_num == '0 || seg_q.repetition == '0) state_d = StSkip;
                else                                                state_d = StKick;
            end
            StSkip: state_d = StIdle;
            StKick: begin
                tmo_d   = '0;
                state_d = StArm;
            end
            StArm: begin
                if (bus.seq_busy)                          state_d = StRun;
                else if (tmo_q == TW'(BUSY_TIMEOUT - 1))   state_d = StFinish;
                else                                       tmo_d   = tmo_q + TW'(1);
            end
            StRun: begin
                if (!bus.seq_busy) state_d = StFinish;
            end
            StFinish: state_d = StIdle;
            StStopping: begin
                if (!bus.seq_busy) state_d = StIdle;
            end
        endcase

        if (abort) begin
            if (state_q == StKick || state_q == StArm || state_q == StRun) begin
                state_d = StStopping;
                stop_d  = 1'b1;
            end else if (state_q != StStopping) begin
                state_d = StIdle;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            tmo_q        <= '0;
            seg_q        <= '0;
            stop_q       <= 1'b0;
            done_count_q <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            stop_q  <= stop_d;
            if (pop) seg_q <= head;
            if (state_q == StSkip || state_q == StFinish) done_count_q <= done_count_q + 32'd1;
        end
    end

    assign bus.seq_data_num   = seg_q.data_num;
    assign bus.seq_repetition = seg_q.repetition;
    assign bus.seq_wait_num   = seg_q.wait_num;
    assign bus.seq_kick       = (state_q == StKick);
    assign bus.seq_stop       = stop_q;
    assign active             = (state_q == StKick) || (state_q == StArm) || (state_q == StRun);
    assign seg_done           = (state_q == StSkip) || (state_q == StFinish);
    assign done_count         = done_count_q;

endmodule

// File: tb/tb_seq_cmd_scheduler.sv
// Directed bench for seq_cmd_scheduler with a small behavioural sequencer model.
module tb_seq_cmd_scheduler;
    import seq_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        abort = 1'b0;
    logic [3:0]  queue_count;
    logic        active, seg_done;
    logic [31:0] done_count;

    int checks = 0;
    int errors = 0;

    logic model_en = 1'b0;
    logic busy_m = 1'b0;
    int   seg_len = 3;
    int   run_cnt = 0;

    int kick_cnt = 0, kick_busy = 0, stop_cnt = 0, done_pulses = 0;
    int log_dn [64];
    int log_rep [64];
    int log_wait [64];
    int log_qc [64];

    seq_cmd_scheduler_if bus();

    seq_cmd_scheduler #(
        .DEPTH        (8),
        .BUSY_TIMEOUT (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .abort       (abort),
        .queue_count (queue_count),
        .active      (active),
        .seg_done    (seg_done),
        .done_count  (done_count)
    );

    always #5 clk = ~clk;

    assign bus.seq_busy = busy_m;

    // Sequencer model: busy rises the edge after a kick and lasts seg_len cycles.
    always @(posedge clk) begin
        if (reset || !model_en) busy_m <= 1'b0;
        else if (bus.seq_stop) busy_m <= 1'b0;
        else if (bus.seq_kick) begin
            busy_m  <= 1'b1;
            run_cnt <= seg_len;
        end else if (busy_m) begin
            if (run_cnt <= 1) busy_m <= 1'b0;
            else run_cnt <= run_cnt - 1;
        end
    end

    always @(posedge clk) begin
        if (bus.seq_kick) begin
            kick_cnt                <= kick_cnt + 1;
            log_dn[kick_cnt % 64]   <= int'(bus.seq_data_num);
            log_rep[kick_cnt % 64]  <= int'(bus.seq_repetition);
            log_wait[kick_cnt % 64] <= int'(bus.seq_wait_num);
            log_qc[kick_cnt % 64]   <= int'(queue_count);
            if (bus.seq_busy) kick_busy <= kick_busy + 1;
        end
        if (bus.seq_stop) stop_cnt <= stop_cnt + 1;
        if (seg_done) done_pulses <= done_pulses + 1;
    end

    task automatic push_desc(input logic [8:0] dn, input logic [31:0] rep, input logic [31:0] wn);
        int t;
        t = 0;
        bus.cmd_data_num   = dn;
        bus.cmd_repetition = rep;
        bus.cmd_wait_num   = wn;
        bus.cmd_valid      = 1'b1;
        while (!bus.cmd_ready && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) begin
            checks++; errors++;
            $display("FAIL push_timeout: cmd_ready=%0b after %0d cycles, want 1", bus.cmd_ready, t);
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %0b want 1", bus.cmd_ready); end
        checks++; if (queue_count !== 4'd0) begin errors++; $display("FAIL reset_queue_count: got %0d want 0", queue_count); end
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL reset_active: got %0b want 0", active); end
        checks++; if (seg_done !== 1'b0) begin errors++; $display("FAIL reset_seg_done: got %0b want 0", seg_done); end
        checks++; if (done_count !== 32'd0) begin errors++; $display("FAIL reset_done_count: got %0d want 0", done_count); end
        checks++; if (bus.seq_kick !== 1'b0) begin errors++; $display("FAIL reset_kick: got %0b want 0", bus.seq_kick); end
        checks++; if (bus.seq_stop !== 1'b0) begin errors++; $display("FAIL reset_stop: got %0b want 0", bus.seq_stop); end
        checks++; if (bus.seq_data_num !== 9'd0) begin errors++; $display("FAIL reset_data_num: got %0d want 0", bus.seq_data_num); end
        checks++; if (bus.seq_repetition !== 32'd0) begin errors++; $display("FAIL reset_rep: got %0d want 0", bus.seq_repetition); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        model_en = 1'b1;
        seg_len  = 3;
        push_desc(9'd1, 32'd1, 32'd0);
        checks++; if (queue_count !== 4'd1) begin errors++; $display("FAIL single_q1: got %0d want 1", queue_count); end
        checks++; if (bus.seq_kick !== 1'b0) begin errors++; $display("FAIL single_early_kick1: got %0b want 0", bus.seq_kick); end
        @(negedge clk);
        checks++; if (bus.seq_data_num !== 9'd1) begin errors++; $display("FAIL single_data_num: got %0d want 1", bus.seq_data_num); end
        checks++; if (bus.seq_kick !== 1'b0) begin errors++; $display("FAIL single_early_kick2: got %0b want 0", bus.seq_kick); end
        checks++; if (queue_count !== 4'd0) begin errors++; $display("FAIL single_q0: got %0d want 0", queue_count); end
        @(negedge clk);
        checks++; if (bus.seq_kick !== 1'b1) begin errors++; $display("FAIL single_kick: got %0b want 1", bus.seq_kick); end
        checks++; if (active !== 1'b1) begin errors++; $display("FAIL single_active: got %0b want 1", active); end
        @(negedge clk);
        checks++; if (bus.seq_kick !== 1'b0) begin errors++; $display("FAIL single_kick_width: got %0b want 0", bus.seq_kick); end
        repeat (4) @(negedge clk);
        checks++; if (seg_done !== 1'b1) begin errors++; $display("FAIL single_seg_done: got %0b want 1", seg_done); end
        @(negedge clk);
        checks++; if (seg_done !== 1'b0) begin errors++; $display("FAIL single_seg_done_width: got %0b want 0", seg_done); end
        checks++; if (done_count !== 32'd1) begin errors++; $display("FAIL single_done_count: got %0d want 1", done_count); end
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL single_idle: got %0b want 0", active); end
    endtask

    task automatic test_back_to_back();
        int k0, b0, t;
        k0 = kick_cnt; b0 = kick_busy; t = 0;
        seg_len = 3;
        push_desc(9'd5, 32'd3, 32'd0);
        push_desc(9'd5, 32'd3, 32'd1);
        push_desc(9'd5, 32'd1, 32'd2);
        while (done_count != 32'd4 && t < 500) begin @(negedge clk); t++; end
        checks++; if (done_count !== 32'd4) begin errors++; $display("FAIL b2b_done_count: got %0d want 4", done_count); end
        checks++; if (kick_cnt - k0 != 3) begin errors++; $display("FAIL b2b_kicks: got %0d want 3", kick_cnt - k0); end
        checks++; if (kick_busy != b0) begin errors++; $display("FAIL b2b_kick_while_busy: got %0d want 0", kick_busy - b0); end
        for (int i = 0; i < 3; i++) begin
            int idx;
            idx = (k0 + i) % 64;
            checks++; if (log_wait[idx] != i) begin errors++; $display("FAIL b2b_order%0d: wait_num %0d want %0d", i, log_wait[idx], i); end
            checks++; if (log_rep[idx] != ((i == 2) ? 1 : 3)) begin errors++; $display("FAIL b2b_rep%0d: got %0d want %0d", i, log_rep[idx], (i == 2) ? 1 : 3); end
            checks++; if (log_qc[idx] != 2 - i) begin errors++; $display("FAIL b2b_qcount%0d: got %0d want %0d", i, log_qc[idx], 2 - i); end
        end
    endtask

    task automatic test_fill();
        int k0, base, t;
        k0 = kick_cnt; base = int'(done_count); t = 0;
        seg_len = 40;
        push_desc(9'd2, 32'd1, 32'd100);
        while (kick_cnt == k0 && t < 50) begin @(negedge clk); t++; end
        for (int i = 0; i < 8; i++) push_desc(9'd3, 32'd1, 32'(i));
        checks++; if (queue_count !== 4'd8) begin errors++; $display("FAIL fill_count: got %0d want 8", queue_count); end
        checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL fill_ready: got %0b want 0", bus.cmd_ready); end
        bus.cmd_data_num = 9'd4; bus.cmd_repetition = 32'd1; bus.cmd_wait_num = 32'd9;
        bus.cmd_valid = 1'b1;
        t = 0;
        while (!bus.cmd_ready && t < 200) begin @(negedge clk); t++; end
        checks++; if (t == 0 || t >= 200) begin errors++; $display("FAIL fill_held: waited %0d cycles, want between 1 and 199", t); end
        checks++; if (queue_count !== 4'd7) begin errors++; $display("FAIL fill_after_pop: got %0d want 7", queue_count); end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        checks++; if (queue_count !== 4'd8) begin errors++; $display("FAIL fill_ninth: got %0d want 8", queue_count); end
        seg_len = 2;
        t = 0;
        while (int'(done_count) != base + 10 && t < 2000) begin @(negedge clk); t++; end
        checks++; if (int'(done_count) != base + 10) begin errors++; $display("FAIL fill_done: got %0d want %0d", done_count, base + 10); end
        checks++; if (log_wait[(k0 + 9) % 64] != 9 || log_dn[(k0 + 9) % 64] != 4) begin
            errors++; $display("FAIL fill_last: wait %0d dn %0d want 9 4", log_wait[(k0 + 9) % 64], log_dn[(k0 + 9) % 64]);
        end
        checks++; if (log_wait[(k0 + 1) % 64] != 0) begin errors++; $display("FAIL fill_first_queued: got %0d want 0", log_wait[(k0 + 1) % 64]); end
    endtask

    task automatic test_skip();
        int k0, p0, base;
        k0 = kick_cnt; p0 = done_pulses; base = int'(done_count);
        push_desc(9'd0, 32'd1, 32'd0);
        push_desc(9'd5, 32'd0, 32'd0);
        repeat (15) @(negedge clk);
        checks++; if (kick_cnt != k0) begin errors++; $display("FAIL skip_kick: got %0d kicks want 0", kick_cnt - k0); end
        checks++; if (done_pulses != p0 + 2) begin errors++; $display("FAIL skip_pulses: got %0d want 2", done_pulses - p0); end
        checks++; if (int'(done_count) != base + 2) begin errors++; $display("FAIL skip_count: got %0d want %0d", done_count, base + 2); end
    endtask

    task automatic test_abort();
        int k0, p0, s0, base, t;
        k0 = kick_cnt; p0 = done_pulses; s0 = stop_cnt; base = int'(done_count); t = 0;
        seg_len = 1000;
        push_desc(9'd5, 32'd10, 32'd2);
        push_desc(9'd5, 32'd1, 32'd0);
        while (kick_cnt == k0 && t < 50) begin @(negedge clk); t++; end
        repeat (110) @(negedge clk);
        checks++; if (queue_count !== 4'd1) begin errors++; $display("FAIL abort_pre_q: got %0d want 1", queue_count); end
        checks++; if (active !== 1'b1) begin errors++; $display("FAIL abort_pre_active: got %0b want 1", active); end
        abort = 1'b1;
        #1;
        checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL abort_ready_gate: got %0b want 0", bus.cmd_ready); end
        @(negedge clk);
        abort = 1'b0;
        checks++; if (bus.seq_stop !== 1'b1) begin errors++; $display("FAIL abort_stop: got %0b want 1", bus.seq_stop); end
        checks++; if (queue_count !== 4'd0) begin errors++; $display("FAIL abort_flush: got %0d want 0", queue_count); end
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL abort_active: got %0b want 0", active); end
        @(negedge clk);
        checks++; if (bus.seq_stop !== 1'b0) begin errors++; $display("FAIL abort_stop_width: got %0b want 0", bus.seq_stop); end
        checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL abort_stopping_ready: got %0b want 0", bus.cmd_ready); end
        @(negedge clk);
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL abort_ready_back: got %0b want 1", bus.cmd_ready); end
        repeat (20) @(negedge clk);
        checks++; if (kick_cnt != k0 + 1) begin errors++; $display("FAIL abort_kicks: got %0d want 1", kick_cnt - k0); end
        checks++; if (done_pulses != p0) begin errors++; $display("FAIL abort_seg_done: got %0d want 0", done_pulses - p0); end
        checks++; if (int'(done_count) != base) begin errors++; $display("FAIL abort_count: got %0d want %0d", done_count, base); end
        checks++; if (stop_cnt != s0 + 1) begin errors++; $display("FAIL abort_stops: got %0d want 1", stop_cnt - s0); end
    endtask

    task automatic test_timeout_reset();
        int base, k0, t;
        base = int'(done_count);
        model_en = 1'b0;
        push_desc(9'd3, 32'd1, 32'd0);
        repeat (2) @(negedge clk);
        checks++; if (bus.seq_kick !== 1'b1) begin errors++; $display("FAIL tmo_kick: got %0b want 1", bus.seq_kick); end
        repeat (4) @(negedge clk);
        checks++; if (seg_done !== 1'b0 || active !== 1'b1) begin errors++; $display("FAIL tmo_early: seg_done %0b active %0b want 0 1", seg_done, active); end
        @(negedge clk);
        checks++; if (seg_done !== 1'b1 || active !== 1'b0) begin errors++; $display("FAIL tmo_finish: seg_done %0b active %0b want 1 0", seg_done, active); end
        @(negedge clk);
        checks++; if (int'(done_count) != base + 1) begin errors++; $display("FAIL tmo_count: got %0d want %0d", done_count, base + 1); end

        model_en = 1'b1;
        seg_len  = 1000;
        k0 = kick_cnt; t = 0;
        push_desc(9'd7, 32'd2, 32'd5);
        push_desc(9'd6, 32'd1, 32'd1);
        while (kick_cnt == k0 && t < 50) begin @(negedge clk); t++; end
        repeat (5) @(negedge clk);
        checks++; if (active !== 1'b1 || queue_count !== 4'd1) begin errors++; $display("FAIL rst_pre: active %0b q %0d want 1 1", active, queue_count); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL rst_active: got %0b want 0", active); end
        checks++; if (done_count !== 32'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", done_count); end
        checks++; if (queue_count !== 4'd0) begin errors++; $display("FAIL rst_queue: got %0d want 0", queue_count); end
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %0b want 1", bus.cmd_ready); end
        checks++; if (bus.seq_data_num !== 9'd0 || bus.seq_wait_num !== 32'd0) begin
            errors++; $display("FAIL rst_fields: dn %0d wait %0d want 0 0", bus.seq_data_num, bus.seq_wait_num);
        end
        checks++; if (seg_done !== 1'b0 || bus.seq_kick !== 1'b0 || bus.seq_stop !== 1'b0) begin
            errors++; $display("FAIL rst_pulses: done %0b kick %0b stop %0b want 0 0 0", seg_done, bus.seq_kick, bus.seq_stop);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        bus.cmd_data_num   = '0;
        bus.cmd_repetition = '0;
        bus.cmd_wait_num   = '0;
        bus.cmd_valid      = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_fill();
        test_skip();
        test_abort();
        test_timeout_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
